// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter
//   Two requesters share one WIDTH-bit shifter. The unit supports SLL, SRL and
//   SRA, plus an optional rotate-right. Arbitration between the requesters is
//   round-robin. A registered result stage holds each result until the
//   consumer takes it. Throughput is one operation per cycle.
//
//   Optional feature: define SHIFT_UNIT_ROTATE_EN to make op 2'b11 a
//   rotate-right. Without the macro, op 2'b11 behaves as SRL and no rotate
//   logic is built.
//
// Ports
//   clk                       rising-edge clock
//   rst                       synchronous active-high reset
//   req0_valid/ready/data/amt/op  requester 0 handshake and operands
//   req1_valid/ready/data/amt/op  requester 1 handshake and operands
//   rsp_valid/ready           result handshake
//   rsp_data                  registered shift result
//   rsp_id                    requester that owns rsp_data
//   busy                      result held (same as rsp_valid)
module shift_unit_arbiter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_amt,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_r, state_s;
  logic             ptr_r;           // 0: req0 has priority under contention
  logic [WIDTH-1:0] data_r;
  logic             id_r;
  logic             can_accept_s;
  logic             grant0_s, grant1_s;
  logic [WIDTH-1:0] op_data_s;
  logic [SHW-1:0]   op_amt_s;
  logic [1:0]       op_op_s;
  logic [WIDTH-1:0] result_s;

  // Log2 staged shifter. Stage s shifts by 2**s when amt[s] is set.
  function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] data,
                                                input logic [SHW-1:0]   amt,
                                                input logic [1:0]       op);
    logic [WIDTH-1:0] res;
    int               sh;
    res = data;
    for (int s = 0; s < SHW; s++) begin
      sh = 1 << s;
      if (amt[s]) begin
        case (op)
          2'b00:   res = res << sh;
          2'b01:   res = res >> sh;
          2'b10:   res = $unsigned($signed(res) >>> sh);
`ifdef SHIFT_UNIT_ROTATE_EN
          2'b11:   res = (res >> sh) | (res << (WIDTH - sh));
`endif
          default: res = res >> sh;  // op 2'b11 falls back to SRL without rotate
        endcase
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration, operand select and next-state decode.
  always_comb begin
    can_accept_s = 1'b0;
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    state_s      = state_r;
    // Ready is suppressed during reset so no grant can leak into the reset cycle.
    if (rst) begin
      can_accept_s = 1'b0;
    end else begin
      can_accept_s = (state_r == EMPTY) || rsp_ready;
    end
    if (can_accept_s) begin
      if (req0_valid && req1_valid) begin
        grant0_s = ~ptr_r;
        grant1_s = ptr_r;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
    if (grant0_s || grant1_s) begin
      state_s = FULL;
    end else if ((state_r == FULL) && !rsp_ready) begin
      state_s = FULL;
    end else begin
      state_s = EMPTY;
    end
  end

  assign op_data_s = grant1_s ? req1_data : req0_data;
  assign op_amt_s  = grant1_s ? req1_amt  : req0_amt;
  assign op_op_s   = grant1_s ? req1_op   : req0_op;
  assign result_s  = shift_fn(op_data_s, op_amt_s, op_op_s);

  // State, priority pointer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
      ptr_r   <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      id_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (grant0_s || grant1_s) begin
        data_r <= result_s;
        id_r   <= grant1_s;
        ptr_r  <= ~grant1_s;  // priority passes to the requester that lost
      end else begin
        data_r <= data_r;
        id_r   <= id_r;
        ptr_r  <= ptr_r;
      end
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp_valid  = (state_r == FULL);
  assign busy       = (state_r == FULL);
  assign rsp_data   = data_r;
  assign rsp_id     = id_r;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
module tb_shift_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_amt, req1_amt;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  int passed = 0;
  int total  = 0;

  // reference model state
  bit          m_full;
  bit          m_ptr;
  bit          m_id;
  logic [31:0] m_data;
  bit          last_g0, last_g1;
  bit          obs_r0, obs_r1;

  shift_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                            input logic [1:0] op);
    case (op)
      2'b00: return d << a;
      2'b01: return d >> a;
      2'b10: return $unsigned($signed(d) >>> a);
`ifdef SHIFT_UNIT_ROTATE_EN
      default: return (d >> a) | (d << (32 - int'(a)));
`else
      default: return d >> a;
`endif
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input bit r,
                       input bit v0, input logic [31:0] d0, input logic [4:0] a0, input logic [1:0] o0,
                       input bit v1, input logic [31:0] d1, input logic [4:0] a1, input logic [1:0] o1,
                       input bit rr);
    bit can, g0, g1;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_data = d0; req0_amt = a0; req0_op = o0;
    req1_valid = v1; req1_data = d1; req1_amt = a1; req1_op = o1;
    rsp_ready = rr;
    #1;
    can = !r && (!m_full || rr);
    g0  = can && v0 && (!v1 || !m_ptr);
    g1  = can && v1 && (!v0 || m_ptr);
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
    chk("busy", {31'd0, busy}, {31'd0, m_full});
    if (m_full) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
    end
    last_g0 = g0;
    last_g1 = g1;
    if (r) begin
      m_full = 0; m_ptr = 0; m_data = 32'd0; m_id = 0;
    end else if (g0 || g1) begin
      m_full = 1;
      m_id   = g1;
      m_data = g1 ? ref_shift(d1, a1, o1) : ref_shift(d0, a0, o0);
      m_ptr  = !g1;
    end else if (rr) begin
      m_full = 0;
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit rr);
    cycle(1'b0, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0, 32'd0, 5'd0, 2'd0, rr);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  bit          p0_v, p1_v;
  logic [31:0] p0_d, p1_d;
  logic [4:0]  p0_a, p1_a;
  logic [1:0]  p0_o, p1_o;
  logic [31:0] held;

  initial begin
    tbl[0] = '{2'b10, 32'h8000_0010, 5'd4,  32'hF800_0001};
    tbl[1] = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[2] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
`ifdef SHIFT_UNIT_ROTATE_EN
    tbl[3] = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000};
`else
    tbl[3] = '{2'b11, 32'h0000_0001, 5'd1,  32'h0000_0000};
`endif
    tbl[4] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    tbl[5] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    tbl[6] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    tbl[7] = '{2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000};
    tbl[8] = '{2'b00, 32'h1234_5678, 5'd8,  32'h3456_7800};
    tbl[9] = '{2'b10, 32'hCAFE_0000, 5'd0,  32'hCAFE_0000};

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_data = 0; req1_data = 0; req0_amt = 0; req1_amt = 0; req0_op = 0; req1_op = 0;
    repeat (2) @(posedge clk);
    m_full = 0; m_ptr = 0; m_data = 32'd0; m_id = 0;

    // reset state
    idle(1'b0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // directed table: one op per entry, result checked the following cycle
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, tbl[i].data, tbl[i].amt, tbl[i].op, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
      @(negedge clk); #1;
      chk($sformatf("table%0d_data", i), rsp_data, tbl[i].exp);
      chk($sformatf("table%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      idle(1'b1);
    end

    // contention straight after reset: grants alternate starting with req0
    cycle(1'b1, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 32'h0000_00F0, 5'd4, 2'b01, 1'b1, 32'h0000_000F, 5'd4, 2'b00, 1'b1);
      chk("contention_req0", {31'd0, obs_r0}, {31'd0, (i % 2) == 0});
      chk("contention_req1", {31'd0, obs_r1}, {31'd0, (i % 2) == 1});
    end
    idle(1'b1);

    // backpressure: result held for 3 cycles, then the next op is accepted
    cycle(1'b0, 1'b1, 32'hA5A5_0000, 5'd16, 2'b01, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
    held = 32'h0000_A5A5;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'h1, 5'd1, 2'b00, 1'b1, 32'h2, 5'd1, 2'b00, 1'b0);
      chk("bp_hold_data", rsp_data, held);
      chk("bp_no_ready", {30'd0, obs_r0, obs_r1}, 32'd0);
    end
    cycle(1'b0, 1'b1, 32'h1, 5'd1, 2'b00, 1'b1, 32'h2, 5'd1, 2'b00, 1'b1);
    chk("bp_release_grant", {30'd0, obs_r0, obs_r1}, 32'd1);  // req1 had priority
    idle(1'b1);

    // reset while FULL: result dropped, pointer back to req0
    cycle(1'b0, 1'b1, 32'h5, 5'd0, 2'b00, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0);
    cycle(1'b1, 1'b1, 32'h5, 5'd0, 2'b00, 1'b1, 32'h6, 5'd0, 2'd0, 1'b0);
    chk("rst_ready_forced0", {30'd0, obs_r0, obs_r1}, 32'd0);
    idle(1'b0);
    chk("rst_full_valid", {31'd0, rsp_valid}, 32'd0);
    cycle(1'b0, 1'b1, 32'h7, 5'd1, 2'b00, 1'b1, 32'h8, 5'd1, 2'd0, 1'b1);
    chk("rst_full_grant0", {31'd0, obs_r0}, 32'd1);
    idle(1'b1);

    // randomized traffic against the model
    p0_v = 0; p1_v = 0;
    for (int i = 0; i < 600; i++) begin
      if (!p0_v && ($urandom_range(0, 9) < 6)) begin
        p0_v = 1; p0_d = $urandom; p0_a = 5'($urandom_range(0, 31)); p0_o = 2'($urandom_range(0, 3));
      end
      if (!p1_v && ($urandom_range(0, 9) < 6)) begin
        p1_v = 1; p1_d = $urandom; p1_a = 5'($urandom_range(0, 31)); p1_o = 2'($urandom_range(0, 3));
      end
      cycle(1'b0, p0_v, p0_d, p0_a, p0_o, p1_v, p1_d, p1_a, p1_o, ($urandom_range(0, 3) != 0));
      if (last_g0) p0_v = 0;
      if (last_g1) p1_v = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
